// File: rtl/fetch_bus_arb.sv
// fetch_bus_arb: round-robin owner arbiter for the core's single TileLink master port.
// Requesters: bit 0 = instruction cache refill, bit 1 = data cache, bit 2 = page-table walker.
// The grant is held for the whole transaction, up to the last D-channel beat. A flush (abort)
// drops the grant but keeps sel on the owner until the response drains. A saturating timeout
// counter force-releases a hung transaction.
//
// Ports:
//   clk           core clock
//   rst_n         asynchronous active-low reset
//   req_i         level request per requester
//   d_last_i      final D-channel beat of the current transaction accepted this cycle
//   abort_i       owner's transaction is no longer wanted; the response still drains
//   grant_o       one-hot grant, registered
//   sel_o         bus mux select; held on the owner through the drain
//   busy_o        high while a transaction is granted or draining
//   timeout_err_o one-cycle pulse when a transaction is force-released
module fetch_bus_arb #(
   parameter int unsigned NREQ    = 3,
   parameter int unsigned TIMEOUT = 1023,
   localparam int unsigned SelW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req_i,
   input  logic            d_last_i,
   input  logic            abort_i,
   output logic [NREQ-1:0] grant_o,
   output logic [SelW-1:0] sel_o,
   output logic            busy_o,
   output logic            timeout_err_o
);

   // Wide enough to reach TIMEOUT; a 1-bit stub when the timeout is disabled.
   localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

   state_e            state_q, state_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [SelW-1:0]   sel_q, sel_d;
   logic [SelW-1:0]   ptr_q, ptr_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              terr_q, terr_d;

   logic              found;
   logic [SelW-1:0]   winner;
   logic [SelW-1:0]   next_ptr;
   logic              cnt_hit;

   // Round-robin search starting at ptr_q, wrapping modulo NREQ.
   always_comb begin
      int unsigned idx;
      found  = 1'b0;
      winner = ptr_q;
      idx    = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = (32'(ptr_q) + i) % NREQ;
         if (!found && req_i[idx]) begin
            found  = 1'b1;
            winner = SelW'(idx);
         end
      end
   end

   assign next_ptr = (sel_q == SelW'(NREQ - 1)) ? '0 : sel_q + 1'b1;
   assign cnt_hit  = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT));

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      terr_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d         = StGrant;
               grant_d         = '0;
               grant_d[winner] = 1'b1;
               sel_d           = winner;
               cnt_d           = '0;
            end
         end
         StGrant, StDrain: begin
            // Saturate rather than wrap so a disabled timeout can never false-fire.
            if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (d_last_i) begin
               // d_last wins over both abort and a coincident timeout.
               state_d = StIdle;
               grant_d = '0;
               ptr_d   = next_ptr;
            end else if (cnt_hit) begin
               state_d = StIdle;
               grant_d = '0;
               ptr_d   = next_ptr;
               terr_d  = 1'b1;
            end else if (abort_i && (state_q == StGrant)) begin
               // Pointer advances now; it is only consulted again once back in idle.
               state_d = StDrain;
               grant_d = '0;
               ptr_d   = next_ptr;
            end
         end
         default: begin
            state_d = StIdle;
            grant_d = '0;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         terr_q  <= terr_d;
      end
   end

   assign grant_o       = grant_q;
   assign sel_o         = sel_q;
   assign busy_o        = busy_q;
   assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_fetch_bus_arb.sv
module tb_fetch_bus_arb;

   localparam int NREQ = 3;
   localparam int TO   = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst0_n;
   logic [2:0] req;
   logic       d_last;
   logic       abort;
   logic [2:0] grant;
   logic [1:0] sel;
   logic       busy;
   logic       terr;

   // Second instance with the timeout disabled, driven by its own fixed stimulus.
   logic [2:0] req0;
   logic       tie0;
   logic [2:0] grant0;
   logic [1:0] sel0;
   logic       busy0;
   logic       terr0;
   logic       done0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_bus_arb #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_i         (req),
      .d_last_i      (d_last),
      .abort_i       (abort),
      .grant_o       (grant),
      .sel_o         (sel),
      .busy_o        (busy),
      .timeout_err_o (terr)
   );

   fetch_bus_arb #(.NREQ(NREQ), .TIMEOUT(0)) dut0 (
      .clk           (clk),
      .rst_n         (rst0_n),
      .req_i         (req0),
      .d_last_i      (tie0),
      .abort_i       (tie0),
      .grant_o       (grant0),
      .sel_o         (sel0),
      .busy_o        (busy0),
      .timeout_err_o (terr0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [2:0] grant;
      logic [1:0] sel;
      logic       busy;
      logic       terr;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: who owns the bus, whether it is draining, how long it has been out.
   int         m_owner = -1;
   bit         m_drain = 1'b0;
   int         m_age   = 0;
   int         m_ptr   = 0;
   logic [1:0] m_sel   = 2'd0;

   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      bit   to;
      bit   hit;
      e   = '0;
      to  = 1'b0;
      hit = 1'b0;
      if (!rst_n) begin
         m_owner = -1;
         m_drain = 1'b0;
         m_age   = 0;
         m_ptr   = 0;
         m_sel   = 2'd0;
         exp_q.delete();
         exp_q.push_back(e);
      end else begin
         if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
               if (!hit && req[(m_ptr + k) % NREQ]) begin
                  hit     = 1'b1;
                  m_owner = (m_ptr + k) % NREQ;
               end
            end
            if (hit) begin
               m_drain = 1'b0;
               m_age   = 0;
               m_sel   = 2'(m_owner);
            end
         end else begin
            to = (m_age == TO) && !d_last;
            if (d_last || to) begin
               m_ptr   = (m_owner + 1) % NREQ;
               m_owner = -1;
               m_drain = 1'b0;
            end else begin
               if (abort) m_drain = 1'b1;
               m_age++;
            end
         end
         e.terr  = to;
         e.grant = (m_owner >= 0 && !m_drain) ? 3'(1 << m_owner) : 3'b000;
         e.sel   = m_sel;
         e.busy  = (m_owner >= 0);
         exp_q.push_back(e);
      end
   end

   // Monitor: compare every presented cycle against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("grant", 32'(grant), 32'(e.grant));
         check("sel", 32'(sel), 32'(e.sel));
         check("busy", 32'(busy), 32'(e.busy));
         check("timeout_err", 32'(terr), 32'(e.terr));
         check("grant_onehot", 32'($countones(grant) <= 1), 32'(1));
      end
   end

   task automatic drive(input logic [2:0] r, input logic dl, input logic ab);
      @(posedge clk);
      #3;
      req    = r;
      d_last = dl;
      abort  = ab;
   endtask

   // Timeout disabled: a transaction with no d_last must never be force-released.
   initial begin
      req0  = 3'b001;
      tie0  = 1'b0;
      done0 = 1'b0;
      repeat (5) @(negedge clk);
      repeat (2000) begin
         @(negedge clk);
         check("no_timeout_err", 32'(terr0), 32'(0));
      end
      check("no_timeout_busy", 32'(busy0), 32'(1));
      check("no_timeout_grant", 32'(grant0), 32'(3'b001));
      done0 = 1'b1;
   end

   initial begin
      rst_n  = 1'b0;
      rst0_n = 1'b0;
      req    = 3'b000;
      d_last = 1'b0;
      abort  = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst_n  = 1'b1;
      rst0_n = 1'b1;

      // Single requester
      drive(3'b001, 1'b0, 1'b0);
      repeat (4) drive(3'b000, 1'b0, 1'b0);
      drive(3'b000, 1'b1, 1'b0);
      repeat (2) drive(3'b000, 1'b0, 1'b0);

      // Fairness with all requesting, four transactions to show the wrap
      for (int t = 0; t < 4; t++) begin
         repeat (3) drive(3'b111, 1'b0, 1'b0);
         drive(3'b111, 1'b1, 1'b0);
      end
      drive(3'b000, 1'b0, 1'b0);

      // Request withdrawn mid-transaction
      drive(3'b010, 1'b0, 1'b0);
      repeat (5) drive(3'b000, 1'b0, 1'b0);
      drive(3'b000, 1'b1, 1'b0);
      drive(3'b000, 1'b0, 1'b0);

      // Abort then drain; a second abort while draining is ignored
      drive(3'b001, 1'b0, 1'b0);
      drive(3'b000, 1'b0, 1'b1);
      repeat (3) drive(3'b000, 1'b0, 1'b0);
      drive(3'b000, 1'b0, 1'b1);
      drive(3'b000, 1'b1, 1'b0);
      drive(3'b000, 1'b0, 1'b0);

      // Abort and d_last together
      drive(3'b100, 1'b0, 1'b0);
      drive(3'b000, 1'b0, 1'b0);
      drive(3'b000, 1'b1, 1'b1);
      drive(3'b000, 1'b0, 1'b0);

      // Timeout while granted
      drive(3'b010, 1'b0, 1'b0);
      repeat (12) drive(3'b000, 1'b0, 1'b0);

      // Timeout while draining
      drive(3'b001, 1'b0, 1'b0);
      drive(3'b000, 1'b0, 1'b1);
      repeat (12) drive(3'b000, 1'b0, 1'b0);

      // d_last on the very cycle the counter reaches the limit
      drive(3'b001, 1'b0, 1'b0);
      repeat (8) drive(3'b000, 1'b0, 1'b0);
      drive(3'b000, 1'b1, 1'b0);
      repeat (2) drive(3'b000, 1'b0, 1'b0);

      // Reset in the middle of a grant
      drive(3'b010, 1'b0, 1'b0);
      drive(3'b000, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_grant", 32'(grant), 32'(0));
      check("rst_sel", 32'(sel), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_timeout_err", 32'(terr), 32'(0));
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      drive(3'b100, 1'b0, 1'b0);
      repeat (3) drive(3'b000, 1'b0, 1'b0);
      drive(3'b000, 1'b1, 1'b0);
      drive(3'b000, 1'b0, 1'b0);

      // Randomized traffic
      repeat (1200) begin
         drive(3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 15) == 0));
      end
      repeat (3) drive(3'b000, 1'b0, 1'b0);

      wait (done0);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_bus_arb.md
# fetch_bus_arb

Round-robin arbiter that shares the core's single TileLink master port between the instruction cache refill path, the data cache and the page-table walker. It sits between the requesters' `request` outputs and the bus mux. It grants one owner per transaction and holds the grant until the last response beat. It also sequences flushes (trap/branch abort) and recovers from hung transactions with a timeout.

## Interface
- `NREQ`, 3: number of requesters; bit 0 = instcache, 1 = dcache, 2 = page walker.
- `TIMEOUT`, 1023: cycles a transaction may stay outstanding before forced release; 0 disables the timeout.
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  level request per requester.
- `d_last`  in  1  final D-channel beat of the current transaction accepted this cycle.
- `abort`  in  1  owner's transaction is no longer wanted (trap_en/bj_en flush); response must still drain.
- `grant`  out  NREQ  one-hot grant; drives the owner's bus handshake.
- `sel`  out  $clog2(NREQ)  bus mux select; stays on the owner through DRAIN.
- `busy`  out  1  high in GRANT and DRAIN.
- `timeout_err`  out  1  one-cycle pulse when a transaction is force-released.

## Operation
- Three states: IDLE, GRANT, DRAIN. Reset state is IDLE.
- Reset values: grant = 0, sel = 0, busy = 0, timeout_err = 0, round-robin pointer = 0, timeout counter = 0.
- Round-robin pointer `ptr`:
  - The highest-priority requester is `ptr`, then ptr+1, … modulo NREQ (wrap from NREQ-1 to 0).
  - After a transaction by requester i completes or aborts, ptr = (i+1) mod NREQ.
  - A timeout also advances ptr.
- IDLE:
  - If any req bit is set, pick the winner by round-robin from ptr and go to GRANT.
  - The next cycle, grant[winner] = 1 and sel = winner.
  - If no req bit is set, stay in IDLE.
- GRANT:
  - grant is held regardless of req; a dropped req does not release the bus because the transaction is in flight.
  - d_last goes to IDLE and grant clears next cycle.
  - abort without d_last goes to DRAIN and grant clears next cycle.
  - abort and d_last in the same cycle: d_last wins and the next state is IDLE.
- DRAIN:
  - grant = 0 and sel holds the owner so the response is consumed and discarded.
  - d_last goes to IDLE.
  - abort is ignored in DRAIN.
- Timeout:
  - The counter clears on entry to GRANT and increments every cycle in GRANT and DRAIN.
  - When the counter equals TIMEOUT and d_last is low: go to IDLE, pulse timeout_err for one cycle coincident with the return to IDLE, and advance ptr.
  - If d_last arrives in the same cycle the counter hits TIMEOUT, d_last wins and there is no error.
  - The counter saturates; it never wraps.
- grant is never multi-hot. grant is never asserted in IDLE or DRAIN.

## Timing
- Arbitration latency: req high at IDLE cycle N gives grant high from cycle N+1.
- Release: d_last at cycle M gives grant low at M+1, state IDLE at M+1.
- Earliest next grant is M+2, so there is a one-cycle bubble between transactions.
- busy is registered and equals (state != IDLE).
- sel changes only on the IDLE→GRANT transition.
- Asserting rst_n low mid-transaction forces every output to its reset value immediately. The interrupted bus transaction is not replayed.

## Test plan
- Single requester: req = 3'b001 at cycle 2 → grant = 001 and sel = 0 at cycle 3; d_last at cycle 7 → grant = 000 at cycle 8; ptr = 1.
- Fairness: req = 3'b111 held for 3 transactions from reset → grants in order 001, 010, 100, each separated by a one-cycle IDLE bubble; a 4th transaction grants 001 (pointer wraps).
- Request withdrawn: grant = 010, then req[1] drops at cycle 5 with no d_last → grant stays 010 until d_last.
- Abort: owner 0 granted, abort at cycle 4 → grant = 000 at cycle 5, sel = 0, busy = 1; d_last at cycle 9 → busy = 0 at cycle 10. abort and d_last together → IDLE directly, busy = 0 next cycle.
- Timeout (TIMEOUT = 8): granted at cycle 1 with no d_last → timeout_err = 1 for exactly one cycle when the counter reaches 8, busy = 0, ptr advanced; TIMEOUT = 0 → no error after 2000 cycles.
- Reset mid-operation: rst_n low during GRANT → grant, sel, busy, timeout_err all 0 within the same cycle; after release with req = 3'b100 → grant = 100 (ptr = 0, no other requests).
